// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: operand width,
// muldiv opcode encoding, controller state type and two's-complement helpers.
package cpu_defs_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } muldiv_state_t;

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
        return (~x) + DATA_W'(1);
    endfunction

    // 0x8000_0000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? negate(x) : x;
    endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, subtract the divisor when it fits, and shift the quotient bit in.
module div_restoring_step
    import cpu_defs_pkg::*;
(
    input  logic [DATA_W:0]   rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W:0]   rem_o,
    output logic [DATA_W-1:0] quo_o
);

    logic [DATA_W+1:0] rem_shift;
    logic [DATA_W:0]   diff;
    logic              fits;

    // The partial remainder stays below the divisor, so only the low bits
    // of the difference matter once the compare says the divisor fits.
    always_comb begin
        rem_shift = {rem_i, quo_i[DATA_W-1]};
        fits      = rem_shift >= {2'b00, divisor_i};
        diff      = rem_shift[DATA_W:0] - {1'b0, divisor_i};
        rem_o     = fits ? diff : rem_shift[DATA_W:0];
        quo_o     = {quo_i[DATA_W-2:0], fits};
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer producing the 64-bit HI/LO write;
// stalls ID/EX while busy and keeps a single result outstanding.
module hilo_muldiv_ctrl
    import cpu_defs_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 1,
    // Tied to the operand width; the datapath assumes one step per bit.
    parameter int unsigned DIV_ITER   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    output logic              busy,
    output logic              stall_req,
    output logic              done,
    output logic              hilo_we,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam int unsigned CNT_MAX = (MUL_CYCLES > DIV_ITER) ? MUL_CYCLES : DIV_ITER;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned PIPE_D  = (MUL_CYCLES > 1) ? MUL_CYCLES - 1 : 1;

    muldiv_state_t state_q, state_d;

    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   opa_q;
    logic [DATA_W-1:0]   opb_q;
    logic [DATA_W:0]     rem_q;
    logic                mul_signed_q;
    logic                q_neg_q;
    logic                r_neg_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    logic                can_accept;
    logic                accept;
    logic                is_div;
    logic                div_signed;
    logic                div_by_zero;
    logic                mul_last;
    logic                div_last;

    logic [2*DATA_W-1:0] mul_a;
    logic [2*DATA_W-1:0] mul_b;
    logic [2*DATA_W-1:0] product;
    logic [2*DATA_W-1:0] mul_res;

    logic [DATA_W:0]     rem_nxt;
    logic [DATA_W-1:0]   quo_nxt;

    always_comb begin
        can_accept  = (state_q == StIdle) || (state_q == StDone);
        accept      = start && !flush && can_accept;
        is_div      = (op == OP_DIV) || (op == OP_DIVU);
        div_signed  = (op == OP_DIV);
        div_by_zero = is_div && (src_b == '0);
        mul_last    = (cnt_q == CNT_W'(MUL_CYCLES - 1));
        div_last    = (cnt_q == CNT_W'(DIV_ITER - 1));
    end

    // Sign- or zero-extend to 64 bits; the truncated product is then exact.
    always_comb begin
        mul_a   = {{DATA_W{mul_signed_q & opa_q[DATA_W-1]}}, opa_q};
        mul_b   = {{DATA_W{mul_signed_q & opb_q[DATA_W-1]}}, opb_q};
        product = mul_a * mul_b;
    end

    // Operand registers form the first multiplier stage; any extra cycles
    // become result registers behind the multiplier.
    if (MUL_CYCLES > 1) begin : g_mul_pipe
        logic [2*DATA_W-1:0] pipe_q [PIPE_D];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < PIPE_D; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= product;
                for (int i = 1; i < PIPE_D; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign mul_res = pipe_q[PIPE_D-1];
    end else begin : g_mul_comb
        assign mul_res = product;
    end

    div_restoring_step u_div_step (
        .rem_i     (rem_q),
        .quo_i     (opa_q),
        .divisor_i (opb_q),
        .rem_o     (rem_nxt),
        .quo_o     (quo_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (!accept) begin
                    state_d = StIdle;
                end else if (!is_div) begin
                    state_d = StMul;
                end else if (div_by_zero) begin
                    state_d = StDone;
                end else begin
                    state_d = StDiv;
                end
            end
            StMul: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (mul_last) begin
                    state_d = StDone;
                end
            end
            StDiv: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (div_last) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q == StMul) || (state_q == StDiv);
        done      = (state_q == StDone);
        hilo_we   = done;
        stall_req = busy || accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            rem_q        <= '0;
            mul_signed_q <= 1'b0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
        end else if (accept) begin
            cnt_q        <= '0;
            rem_q        <= '0;
            mul_signed_q <= (op == OP_MULT);
            q_neg_q      <= div_signed && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
            r_neg_q      <= div_signed && src_a[DATA_W-1];
            if (is_div) begin
                opa_q <= div_signed ? abs_val(src_a) : src_a;
                opb_q <= div_signed ? abs_val(src_b) : src_b;
                if (div_by_zero) begin
                    hi_q <= src_a;
                    lo_q <= '1;
                end
            end else begin
                opa_q <= src_a;
                opb_q <= src_b;
            end
        end else if (state_q == StMul) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (mul_last && !flush) begin
                hi_q <= mul_res[2*DATA_W-1:DATA_W];
                lo_q <= mul_res[DATA_W-1:0];
            end
        end else if (state_q == StDiv) begin
            cnt_q <= cnt_q + CNT_W'(1);
            rem_q <= rem_nxt;
            opa_q <= quo_nxt;
            // Sign fix-up rides on the final step so DONE sees the signed result.
            if (div_last && !flush) begin
                hi_q <= r_neg_q ? negate(rem_nxt[DATA_W-1:0]) : rem_nxt[DATA_W-1:0];
                lo_q <= q_neg_q ? negate(quo_nxt) : quo_nxt;
            end
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed and random operations
// against an arithmetic reference model, plus flush/reset/back-to-back cases.
module tb_hilo_muldiv_ctrl;

    localparam int unsigned MUL_CYCLES = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic        hilo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    always #5 clk = ~clk;

    hilo_muldiv_ctrl #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_ITER   (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .hilo_we   (hilo_we),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic, SV division truncates toward zero.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] hi,
                                      output logic [31:0] lo);
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: p = sa * sb;
            2'b01: p = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p  = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
            end
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    // Samples on negedges from the current cycle; returns -1 if no done seen.
    task automatic wait_done(input int c0, input int limit, output int lat);
        lat = -1;
        for (int c = c0; c <= limit; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            tick();
        end
    endtask

    // Issues one request in cycle 0 and records latency and stall/busy profile.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int n_stall, output int n_busy,
                         output logic st_done, output logic we_done);
        op      = o;
        src_a   = a;
        src_b   = b;
        start   = 1'b1;
        lat     = -1;
        n_stall = 0;
        n_busy  = 0;
        st_done = 1'bx;
        we_done = 1'bx;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat     = c;
                st_done = stall_req;
                we_done = hilo_we;
                break;
            end
            n_stall += int'(stall_req);
            n_busy  += int'(busy);
            tick();
            start = 1'b0;
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        src_a = '0;
        src_b = '0;
        tick();
        tick();
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset.busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset.done got=%b want=0", done); end
        total++; if (hilo_we !== 1'b0) begin bad++; $display("FAIL reset.hilo_we got=%b want=0", hilo_we); end
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset.stall got=%b want=0", stall_req); end
        total++; if (hi_out !== 32'd0) begin bad++; $display("FAIL reset.hi got=%h want=0", hi_out); end
        total++; if (lo_out !== 32'd0) begin bad++; $display("FAIL reset.lo got=%h want=0", lo_out); end
        tick();
        rst     = 1'b0;
        last_hi = '0;
        last_lo = '0;
    endtask

    task automatic test_directed();
        logic [1:0]  t_op  [5] = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b11};
        logic [31:0] t_a   [5] = '{32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5};
        logic [31:0] t_b   [5] = '{32'd5, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] t_hi  [5] = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd5};
        logic [31:0] t_lo  [5] = '{32'hFFFF_FFF1, 32'd14, 32'hFFFF_FFFD, 32'h8000_0000,
                                   32'hFFFF_FFFF};
        int          t_lat [5] = '{2, 33, 33, 33, 1};
        int          lat;
        int          ns;
        int          nb;
        logic        sd;
        logic        wd;
        for (int i = 0; i < 5; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], lat, ns, nb, sd, wd);
            total++; if (lat !== t_lat[i]) begin bad++; $display("FAIL dir%0d.latency got=%0d want=%0d", i, lat, t_lat[i]); end
            total++; if (hi_out !== t_hi[i]) begin bad++; $display("FAIL dir%0d.hi got=%h want=%h", i, hi_out, t_hi[i]); end
            total++; if (lo_out !== t_lo[i]) begin bad++; $display("FAIL dir%0d.lo got=%h want=%h", i, lo_out, t_lo[i]); end
            total++; if (ns !== t_lat[i]) begin bad++; $display("FAIL dir%0d.stall_cycles got=%0d want=%0d", i, ns, t_lat[i]); end
            total++; if (nb !== t_lat[i] - 1) begin bad++; $display("FAIL dir%0d.busy_cycles got=%0d want=%0d", i, nb, t_lat[i] - 1); end
            total++; if (sd !== 1'b0) begin bad++; $display("FAIL dir%0d.stall_in_done got=%b want=0", i, sd); end
            total++; if (wd !== 1'b1) begin bad++; $display("FAIL dir%0d.hilo_we got=%b want=1", i, wd); end
            last_hi = t_hi[i];
            last_lo = t_lo[i];
        end
    endtask

    task automatic test_random(input int n);
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          el_lat;
        int          lat;
        int          ns;
        int          nb;
        logic        sd;
        logic        wd;
        for (int i = 0; i < n; i++) begin
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            ref_model(o, a, b, eh, el);
            if (!o[1])           el_lat = MUL_CYCLES + 1;
            else if (b == 32'd0) el_lat = 1;
            else                 el_lat = 33;
            do_op(o, a, b, lat, ns, nb, sd, wd);
            total++; if (lat !== el_lat) begin bad++; $display("FAIL rnd%0d.latency op=%0d got=%0d want=%0d", i, o, lat, el_lat); end
            total++; if (hi_out !== eh) begin bad++; $display("FAIL rnd%0d.hi op=%0d a=%h b=%h got=%h want=%h", i, o, a, b, hi_out, eh); end
            total++; if (lo_out !== el) begin bad++; $display("FAIL rnd%0d.lo op=%0d a=%h b=%h got=%h want=%h", i, o, a, b, lo_out, el); end
            total++; if (wd !== 1'b1) begin bad++; $display("FAIL rnd%0d.hilo_we got=%b want=1", i, wd); end
            last_hi = eh;
            last_lo = el;
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        op = 2'b11; src_a = 32'd1000; src_b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        op = 2'b01; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(6, 40, lat);
        total++; if (lat !== 33) begin bad++; $display("FAIL ignored.latency got=%0d want=33", lat); end
        total++; if (hi_out !== 32'd1) begin bad++; $display("FAIL ignored.hi got=%h want=1", hi_out); end
        total++; if (lo_out !== 32'd111) begin bad++; $display("FAIL ignored.lo got=%h want=6f", lo_out); end
        tick();
        wait_done(34, 45, lat);
        total++; if (lat !== -1) begin bad++; $display("FAIL ignored.extra_done got=%0d want=none", lat); end
        tick();
        last_hi = 32'd1;
        last_lo = 32'd111;
    endtask

    task automatic test_flush_busy();
        int lat;
        op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush.busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL flush.done got=%b want=0", done); end
        tick();
        wait_done(12, 50, lat);
        total++; if (lat !== -1) begin bad++; $display("FAIL flush.no_done got=%0d want=none", lat); end
        tick();
        total++; if (hi_out !== last_hi) begin bad++; $display("FAIL flush.hi got=%h want=%h", hi_out, last_hi); end
        total++; if (lo_out !== last_lo) begin bad++; $display("FAIL flush.lo got=%h want=%h", lo_out, last_lo); end
    endtask

    task automatic test_back_to_back();
        int lat;
        op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1, 40, lat);
        total++; if (lat !== 33) begin bad++; $display("FAIL b2b.first_latency got=%0d want=33", lat); end
        total++; if (hi_out !== 32'd2 || lo_out !== 32'd14) begin bad++; $display("FAIL b2b.first_result got=%h_%h want=2_e", hi_out, lo_out); end
        op = 2'b01; src_a = 32'h0001_0000; src_b = 32'h0001_0000; start = 1'b1;
        #1;
        total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL b2b.stall_on_accept got=%b want=1", stall_req); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b.done_held got=%b want=1", done); end
        tick();
        start = 1'b0;
        wait_done(34, 40, lat);
        total++; if (lat !== 35) begin bad++; $display("FAIL b2b.second_latency got=%0d want=35", lat); end
        total++; if (hi_out !== 32'd1) begin bad++; $display("FAIL b2b.second_hi got=%h want=1", hi_out); end
        total++; if (lo_out !== 32'd0) begin bad++; $display("FAIL b2b.second_lo got=%h want=0", lo_out); end
        tick();
        last_hi = 32'd1;
        last_lo = 32'd0;
    endtask

    task automatic test_flush_in_done();
        int lat;
        op = 2'b00; src_a = 32'hFFFF_FFFE; src_b = 32'hFFFF_FFFD; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1, 10, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL fdone.latency got=%0d want=2", lat); end
        op = 2'b11; src_a = 32'd50; src_b = 32'd0; start = 1'b1; flush = 1'b1;
        #1;
        total++; if (done !== 1'b1 || hilo_we !== 1'b1) begin bad++; $display("FAIL fdone.done got=%b%b want=11", done, hilo_we); end
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL fdone.stall got=%b want=0", stall_req); end
        tick();
        start = 1'b0;
        flush = 1'b0;
        wait_done(3, 20, lat);
        total++; if (lat !== -1) begin bad++; $display("FAIL fdone.dropped_request got=%0d want=none", lat); end
        tick();
        total++; if (hi_out !== 32'd0) begin bad++; $display("FAIL fdone.hi got=%h want=0", hi_out); end
        total++; if (lo_out !== 32'd6) begin bad++; $display("FAIL fdone.lo got=%h want=6", lo_out); end
    endtask

    task automatic test_rst_mid();
        int lat;
        op = 2'b10; src_a = 32'hFFFF_FF9C; src_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid.busy got=%b want=0", busy); end
        total++; if (hi_out !== 32'd0 || lo_out !== 32'd0) begin bad++; $display("FAIL rstmid.hilo got=%h_%h want=0_0", hi_out, lo_out); end
        tick();
        wait_done(9, 50, lat);
        total++; if (lat !== -1) begin bad++; $display("FAIL rstmid.no_done got=%0d want=none", lat); end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_random(40);
        test_start_ignored();
        test_flush_busy();
        test_back_to_back();
        test_flush_in_done();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer that produces the 64-bit HI/LO write for the register file's HI/LO port (hl_data / hl_write_enable path).
- Sits beside EX: accepts one MULT/MULTU/DIV/DIVU per request, iterates, then pulses a HI/LO write.
- While an operation is in flight it raises a stall request to the hazard unit, so ID/EX hold.
- Serialises all HI/LO producers so only one result is ever outstanding.

Parameters:
MUL_CYCLES, 1, cycles spent in MUL state before done (>=1); models a pipelined multiplier.
DIV_ITER, 32, restoring-division iterations; fixed to operand width, not to be overridden.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset, sampled on rising edge of clk
start  in  1  request valid; sampled only in IDLE or DONE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; valid with start
src_a  in  32  rs operand (dividend / multiplicand)
src_b  in  32  rt operand (divisor / multiplier)
flush  in  1  exception/eret cancel; kills in-flight op
busy  out  1  high while in MUL or DIV state
stall_req  out  1  combinational: busy | (start & ~flush & state in {IDLE,DONE})
done  out  1  one-cycle pulse, result valid
hilo_we  out  1  equals done; HI/LO write enable toward WB
hi_out  out  32  HI result (remainder / product[63:32])
lo_out  out  32  LO result (quotient / product[31:0])

Behaviour:
- Reset: state=IDLE; busy, done, hilo_we = 0; hi_out, lo_out = 0; iteration counter = 0.
- States: IDLE, MUL, DIV, DONE.
- Transitions from IDLE or DONE:
  - start & ~flush & op[1]=0 -> MUL; operands latched.
  - start & ~flush & op[1]=1 & src_b!=0 -> DIV; abs values and sign flags latched (signed only).
  - start & ~flush & op[1]=1 & src_b==0 -> DONE directly; HI=src_a, LO=32'hFFFF_FFFF.
  - Otherwise -> IDLE.
- MUL: counts MUL_CYCLES cycles, then -> DONE.
  - MULT: signed 64-bit product. MULTU: unsigned 64-bit product.
- DIV: one restoring step per cycle, counter 0..31, then -> DONE.
  - Signed fix-up applied in the final step: quotient negated if signs differ; remainder takes dividend's sign.
  - 0x8000_0000 / 0xFFFF_FFFF (DIV) yields LO=0x8000_0000, HI=0. This falls out of unsigned abs; no special case.
- DONE: done=hilo_we=1 for exactly this cycle; hi_out/lo_out updated on entry and held until the next DONE.
- Latency, start sampled in cycle 0:
  - MUL: done in cycle MUL_CYCLES+1.
  - DIV: done in cycle 33.
  - Divide by zero: done in cycle 1.
- stall_req is high from cycle 0 through the last busy cycle; low in the DONE cycle.
- start while busy: ignored; the in-flight op is unaffected.
- start in the DONE cycle: accepted back-to-back; done still pulses for the old result.
- flush in MUL/DIV: next state IDLE; no done; hi_out/lo_out keep their previous values.
- flush in DONE: done still asserts; the already-committed result is not cancelled.
- flush and start in the same cycle: flush wins; request dropped.
- rst mid-operation: immediate return to reset values; no done.

Decomposition:
- Shared package (cpu_defs_pkg):
  - muldiv op encoding constants: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - muldiv_state_t enum.
  - DATA_W = 32.
- One sub-module: div_restoring_step.
  - Combinational single iteration.
  - In: partial remainder (33b), quotient shift reg (32b), divisor (32b).
  - Out: next remainder, next quotient.
- Multiplier is an inferred `*` inside the controller, with a result register per MUL_CYCLES stage.

Test Plan:
1. MULT src_a=0xFFFF_FFFD (-3), src_b=5, MUL_CYCLES=1 -> done in cycle 2, HI=0xFFFF_FFFF, LO=0xFFFF_FFF1; stall_req high cycles 0-1.
2. DIVU 100/7 -> done exactly in cycle 33, LO=14, HI=2; busy high cycles 1-32, stall_req low in cycle 33.
3. DIV -7/2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
4. DIV 0x8000_0000/0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
5. DIVU 5/0 -> done in cycle 1, HI=5, LO=0xFFFF_FFFF.
6. DIVU started, then:
   - flush in cycle 10 -> no done, hi/lo unchanged, busy=0 in cycle 11.
   - start in cycle 5 of a running DIV is ignored.
   - start in the DONE cycle begins a new op immediately.
